// File: rtl/fft_pkg.sv
// Shared definitions for the FFT back end: default sizes, reorder FSM states
// and a width-generic bit-reverse helper.
package fft_pkg;

  localparam int unsigned DEF_WORDSIZE   = 16;
  localparam int unsigned DEF_NUMSAMPLES = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    DRAIN   = 2'b10
  } state_t;

  // Reverse the low nbits of a; upper result bits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] a, input int unsigned nbits);
    logic [31:0] r;
    r = {<<{a}};
    return r >> (32 - nbits);
  endfunction

endpackage

// File: rtl/reorder_mem.sv
// Frame buffer: LANES writes per cycle to bit-reversed slots, one registered read.
module reorder_mem
  import fft_pkg::*;
#(
  parameter  int unsigned WORDSIZE   = DEF_WORDSIZE,
  parameter  int unsigned NUMSAMPLES = DEF_NUMSAMPLES,
  parameter  int unsigned LANES      = 4,
  localparam int unsigned ADDRBITS   = $clog2(NUMSAMPLES),
  localparam int unsigned LANEBITS   = $clog2(LANES),
  localparam int unsigned BEATBITS   = $clog2(NUMSAMPLES / LANES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [BEATBITS-1:0] wr_beat,
  input  logic [WORDSIZE-1:0] wr_data [LANES],
  input  logic                rd_en,
  input  logic [ADDRBITS-1:0] rd_addr,
  output logic [WORDSIZE-1:0] rd_data
);

  logic [WORDSIZE-1:0] mem [NUMSAMPLES];
  logic [ADDRBITS-1:0] wr_addr [LANES];

  // Lane j of beat k holds FFT position LANES*k+j; its natural slot is the bit-reverse.
  always_comb begin
    for (int j = 0; j < int'(LANES); j++) begin
      wr_addr[j] = ADDRBITS'(bitrev(32'({wr_beat, LANEBITS'(j)}), ADDRBITS));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < int'(LANES); j++) begin
        mem[wr_addr[j]] <= wr_data[j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fft_output_reorder.sv
// Captures one bit-reversed 4-lane FFT frame and streams it out in natural
// order over valid/ready; single-frame buffer.
module fft_output_reorder
  import fft_pkg::*;
#(
  parameter  int unsigned WORDSIZE   = DEF_WORDSIZE,
  parameter  int unsigned NUMSAMPLES = DEF_NUMSAMPLES,
  parameter  int unsigned LANES      = 4,
  localparam int unsigned ADDRBITS   = $clog2(NUMSAMPLES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [WORDSIZE-1:0] in0,
  input  logic [WORDSIZE-1:0] in1,
  input  logic [WORDSIZE-1:0] in2,
  input  logic [WORDSIZE-1:0] in3,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] out_data,
  output logic [ADDRBITS-1:0] out_index,
  output logic                out_last,
  output logic                frame_done,
  output logic                ovf_err
);

  localparam int unsigned NUMBEATS  = NUMSAMPLES / LANES;
  localparam int unsigned BEATBITS  = $clog2(NUMBEATS);
  localparam logic [BEATBITS-1:0] LAST_BEAT = BEATBITS'(NUMBEATS - 1);
  localparam logic [ADDRBITS-1:0] LAST_IDX  = ADDRBITS'(NUMSAMPLES - 1);

  state_t              state, state_next;
  logic [BEATBITS-1:0] beat_cnt, beat_cnt_d;
  logic [ADDRBITS-1:0] rd_cnt, rd_cnt_d, rd_inc, rd_addr;
  logic                wr_en, rd_en, xfer;
  logic                in_ready_d, out_valid_d, out_last_d, frame_done_d, ovf_err_d;
  logic [WORDSIZE-1:0] wr_data [LANES];

  assign wr_data   = '{in0, in1, in2, in3};
  assign rd_inc    = rd_cnt + 1'b1;
  assign xfer      = out_valid & out_ready;
  assign out_index = rd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CAPTURE;
      CAPTURE: if (in_valid && beat_cnt == LAST_BEAT) state_next = DRAIN;
      DRAIN:   if (xfer && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/counter decode; DRAIN primes the read register once, then reloads on each transfer.
  always_comb begin
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = rd_cnt;
    beat_cnt_d   = beat_cnt;
    rd_cnt_d     = rd_cnt;
    out_valid_d  = out_valid;
    out_last_d   = out_last;
    frame_done_d = 1'b0;
    ovf_err_d    = ovf_err | (in_valid & ~in_ready);
    in_ready_d   = (state_next != DRAIN);
    case (state)
      IDLE, CAPTURE: begin
        if (in_valid) begin
          wr_en      = 1'b1;
          beat_cnt_d = (state == CAPTURE && beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (!out_valid) begin
          rd_en       = 1'b1;
          out_valid_d = 1'b1;
          out_last_d  = (rd_cnt == LAST_IDX);
        end else if (xfer) begin
          if (out_last) begin
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            rd_cnt_d     = '0;
            frame_done_d = 1'b1;
          end else begin
            rd_en      = 1'b1;
            rd_addr    = rd_inc;
            rd_cnt_d   = rd_inc;
            out_last_d = (rd_inc == LAST_IDX);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt   <= '0;
      rd_cnt     <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      beat_cnt   <= beat_cnt_d;
      rd_cnt     <= rd_cnt_d;
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
      out_last   <= out_last_d;
      frame_done <= frame_done_d;
      ovf_err    <= ovf_err_d;
    end
  end

  reorder_mem #(
    .WORDSIZE  (WORDSIZE),
    .NUMSAMPLES(NUMSAMPLES),
    .LANES     (LANES)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_beat(beat_cnt),
    .wr_data(wr_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(out_data)
  );

endmodule
